// File: rtl/add_4bit_if.sv
// add_4bit_if: adder operand/result bundle; master drives A/B/Cin, slave returns S/Cout/OV/Z
interface add_4bit_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       OV;
  logic       Z;
  modport master (output A, B, Cin, input S, Cout, OV, Z);
  modport slave (input A, B, Cin, output S, Cout, OV, Z);
endinterface

// File: rtl/add_4bit.sv
// add_4bit: ripple-carry A+B+Cin with registered S/Cout/OV/Z (clk, async active-high rst, bus slave)
module add_4bit (
  input  logic        clk,
  input  logic        rst,
  add_4bit_if.slave   bus
);
  logic [4:0] c;
  logic [3:0] s;
  assign c[0] = bus.Cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (.a(bus.A[i]), .b(bus.B[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.S    <= 4'h0;
      bus.Cout <= 1'b0;
      bus.OV   <= 1'b0;
      bus.Z    <= 1'b1;
    end else begin
      bus.S    <= s;
      bus.Cout <= c[4];
      bus.OV   <= c[3] ^ c[4];
      bus.Z    <= s == 4'h0;
    end
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: tb/tb_add_4bit.sv
// tb_add_4bit: directed vectors, latency, exhaustive sweep and mid-stream reset for add_4bit
module tb_add_4bit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  add_4bit_if bus ();
  add_4bit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ov;
    logic       z;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string name, input logic [6:0] req);
    logic [6:0] got;
    got = {bus.S, bus.Cout, bus.OV, bus.Z};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got S=%h Cout=%b OV=%b Z=%b, required S=%h Cout=%b OV=%b Z=%b",
               name, got[6:3], got[2], got[1], got[0], req[6:3], req[2], req[1], req[0]);
    end
  endtask
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] sum;
    logic ov;
    sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    ov = (a[3] == b[3]) && (sum[3] != a[3]);
    return {sum[3:0], sum[4], ov, sum[3:0] == 4'h0};
  endfunction
  initial begin
    logic [6:0] prev;
    vecs[0] = '{4'h0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'h9, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    bus.A = 4'h5;
    bus.B = 4'h5;
    bus.Cin = 1'b1;
    #1;
    chk("reset_no_clock", 7'b0000_0_0_1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_release_hold", 7'b0000_0_0_1);
    @(posedge clk);
    #1;
    chk("first_capture", 7'b1011_0_1_0);
    prev = 7'b1011_0_1_0;
    foreach (vecs[i]) begin
      bus.A = vecs[i].a;
      bus.B = vecs[i].b;
      bus.Cin = vecs[i].cin;
      #2;
      chk($sformatf("hold_before_edge_%0d", i), prev);
      @(posedge clk);
      #1;
      prev = {vecs[i].s, vecs[i].cout, vecs[i].ov, vecs[i].z};
      chk($sformatf("vector_%0d", i), prev);
    end
    for (int n = 0; n < 512; n++) begin
      bus.A = n[3:0];
      bus.B = n[7:4];
      bus.Cin = n[8];
      if (n == 200) begin
        #1;
        rst = 1'b1;
        #1;
        chk("midstream_reset", 7'b0000_0_0_1);
        #1;
        rst = 1'b0;
        #1;
        chk("midstream_reset_hold", 7'b0000_0_0_1);
      end
      @(posedge clk);
      #1;
      chk($sformatf("sweep_a%0h_b%0h_c%0b", n[3:0], n[7:4], n[8]), model(n[3:0], n[7:4], n[8]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
